// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Prescaled down-counter sequencer with config handshake, run
//            control, one-shot/auto-reload, done pulse and sticky irq.
// Revision : 1.0
// ============================================================================
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_reg;
  logic [WIDTH-1:0] period_reg;
  logic             reload_reg;

  logic             cfg_fire;
  logic             start_fire;
  logic [WIDTH-1:0] eff_period;
  logic             terminal;
  logic             done_set;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cfg_fire   = cfg_valid & cfg_ready;
  // A config accepted on the start edge is used immediately.
  assign eff_period = cfg_fire ? cfg_period : period_reg;
  assign start_fire = (state == IDLE) & start & ~stop;
  assign tick       = (state == RUN) & ~pause & ~stop & (presc == div_reg);
  assign terminal   = tick & (count == WIDTH'(1));
  assign done_set   = (start_fire & (eff_period == '0)) | terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      presc      <= '0;
      div_reg    <= '0;
      period_reg <= '0;
      reload_reg <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= done_set;
      if (cfg_fire) begin
        period_reg <= cfg_period;
        div_reg    <= cfg_div;
        reload_reg <= cfg_reload;
      end
      case (state)
        IDLE: begin
          if (start_fire && (eff_period != '0)) begin
            count <= eff_period;
            presc <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            count <= '0;
            presc <= '0;
            state <= IDLE;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            presc <= '0;
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (terminal) begin
              if (reload_reg) begin
                count <= period_reg;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        PAUSED: begin
          if (stop) begin
            count <= '0;
            presc <= '0;
            state <= IDLE;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (done_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule
`default_nettype wire
